// File: rtl/op_sched_pkg.sv
// Shared types and constants for the op_scheduler slice: FSM states,
// datapath op encodings, requester ids and a saturating counter helper.
package op_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OP_0 = 2'b00;
  localparam logic [1:0] OP_1 = 2'b01;
  localparam logic [1:0] OP_2 = 2'b10;
  localparam logic [1:0] OP_3 = 2'b11;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/op_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// The last-grant pointer resets to requester B so that A wins the first tie.
module rr_arb2
  import op_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_r;

  // Grant selection: a lone request wins outright, a tie goes to the other side.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (last_r == ID_B) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Last-grant pointer, moved only when a grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= ID_B;
    end else if (advance) begin
      last_r <= grant[1];
    end
  end

endmodule

// File: rtl/op_scheduler.sv
// Two-requester scheduler for one shared external datapath; one operation in flight.
// Optional build macro OP_SCHEDULER_PERF_EN adds saturating performance counters.
module op_scheduler
  import op_sched_pkg::*;
#(
  parameter int DW   = 16,
  parameter int HOLD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [DW-1:0]   req_in1_a,
  input  logic [DW-1:0]   req_in2_a,
  input  logic [DW-1:0]   req_in3_a,
  input  logic [DW-1:0]   req_in1_b,
  input  logic [DW-1:0]   req_in2_b,
  input  logic [DW-1:0]   req_in3_b,
  input  logic [1:0]      req_op_a,
  input  logic [1:0]      req_op_b,
  output logic [DW-1:0]   dp_in1,
  output logic [DW-1:0]   dp_in2,
  output logic [DW-1:0]   dp_in3,
  output logic [1:0]      dp_in4,
  input  logic [2*DW-1:0] dp_out1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_data,
  output logic            rsp_id
`ifdef OP_SCHEDULER_PERF_EN
  ,
  output logic [15:0]     perf_ops_a,
  output logic [15:0]     perf_ops_b,
  output logic [15:0]     perf_stall
`endif
);

  localparam logic [2:0] HOLD_LOAD = 3'(HOLD - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] grant_s;
  logic       xfer_s;
  logic       sel_b_s;
  logic       id_r;
  logic [2:0] hold_cnt_r;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer_s),
    .grant   (grant_s)
  );

  // Ready is combinational so a request can transfer on the first edge out of reset.
  always_comb begin
    req_ready = 2'b00;
    if (!rst && (state_r == ST_IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign xfer_s  = |(req_valid & req_ready);
  assign sel_b_s = req_ready[1];

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) state_nxt_s = ST_ISSUE;
        else        state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (hold_cnt_r == 3'd0) state_nxt_s = ST_CAPTURE;
        else                    state_nxt_s = ST_ISSUE;
      end
      ST_CAPTURE: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand, op and owner registers; dp_in* hold everywhere except on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_in1 <= '0;
      dp_in2 <= '0;
      dp_in3 <= '0;
      dp_in4 <= OP_0;
      id_r   <= ID_A;
    end else if (xfer_s) begin
      dp_in1 <= sel_b_s ? req_in1_b : req_in1_a;
      dp_in2 <= sel_b_s ? req_in2_b : req_in2_a;
      dp_in3 <= sel_b_s ? req_in3_b : req_in3_a;
      dp_in4 <= sel_b_s ? req_op_b  : req_op_a;
      id_r   <= sel_b_s;
    end
  end

  // Settle down-counter: loaded on transfer, expires after HOLD ISSUE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= 3'd0;
    end else if (xfer_s) begin
      hold_cnt_r <= HOLD_LOAD;
    end else if ((state_r == ST_ISSUE) && (hold_cnt_r != 3'd0)) begin
      hold_cnt_r <= hold_cnt_r - 3'd1;
    end
  end

  // Response registers: captured in CAPTURE, held through RESP until the consumer takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= ID_A;
    end else if (state_r == ST_CAPTURE) begin
      rsp_valid <= 1'b1;
      rsp_data  <= dp_out1;
      rsp_id    <= id_r;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef OP_SCHEDULER_PERF_EN
  // Saturating counts of completed responses per requester and of stalled RESP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_a <= 16'd0;
      perf_ops_b <= 16'd0;
      perf_stall <= 16'd0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (rsp_id == ID_B) perf_ops_b <= sat_inc16(perf_ops_b);
        else                perf_ops_a <= sat_inc16(perf_ops_a);
      end
      if (rsp_valid && !rsp_ready) begin
        perf_stall <= sat_inc16(perf_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_op_scheduler.sv
// Scoreboard bench for op_scheduler: a round-robin reference model predicts
// grants and results, a separate monitor pops and compares each response.
module tb_op_scheduler;

  localparam int DW     = 16;
  localparam int HOLD_M = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] in1_a, in2_a, in3_a, in1_b, in2_b, in3_b;
  logic [1:0]  op_a, op_b;
  logic [15:0] dp_in1, dp_in2, dp_in3;
  logic [1:0]  dp_in4;
  logic [31:0] dp_out1;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        stub_force;
  logic [31:0] stub_val;

  // second instance, HOLD=4, directed
  logic [1:0]  h4_valid, h4_ready;
  logic [15:0] h4_in1, h4_in2, h4_in3;
  logic [1:0]  h4_op;
  logic [15:0] h4_dp_in1, h4_dp_in2, h4_dp_in3;
  logic [1:0]  h4_dp_in4;
  logic [31:0] h4_dp_out, h4_rsp_data;
  logic        h4_rsp_valid, h4_rsp_id;

`ifdef OP_SCHEDULER_PERF_EN
  logic [15:0] perf_ops_a, perf_ops_b, perf_stall;
  logic [15:0] h4_perf_a, h4_perf_b, h4_perf_s;
`endif

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // reference datapath: behaviour of the external unit the scheduler feeds
  function automatic logic [31:0] dp_model(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'd0:    r = {16'd0, a} * {16'd0, b};
      2'd1:    r = {16'd0, a} + {16'd0, b} + {16'd0, c};
      2'd2:    r = {a, b} ^ {16'd0, c};
      default: r = ({16'd0, a} * {16'd0, b}) + {16'd0, c};
    endcase
    return r;
  endfunction

  always_comb dp_out1 = stub_force ? stub_val : dp_model(dp_in1, dp_in2, dp_in3, dp_in4);

  op_scheduler #(.DW(DW), .HOLD(HOLD_M)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1_a(in1_a), .req_in2_a(in2_a), .req_in3_a(in3_a),
    .req_in1_b(in1_b), .req_in2_b(in2_b), .req_in3_b(in3_b),
    .req_op_a(op_a), .req_op_b(op_b),
    .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_in3(dp_in3), .dp_in4(dp_in4),
    .dp_out1(dp_out1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef OP_SCHEDULER_PERF_EN
    , .perf_ops_a(perf_ops_a), .perf_ops_b(perf_ops_b), .perf_stall(perf_stall)
`endif
  );

  op_scheduler #(.DW(DW), .HOLD(4)) dut_h4 (
    .clk(clk), .rst(rst), .req_valid(h4_valid), .req_ready(h4_ready),
    .req_in1_a(h4_in1), .req_in2_a(h4_in2), .req_in3_a(h4_in3),
    .req_in1_b(16'd0), .req_in2_b(16'd0), .req_in3_b(16'd0),
    .req_op_a(h4_op), .req_op_b(2'b00),
    .dp_in1(h4_dp_in1), .dp_in2(h4_dp_in2), .dp_in3(h4_dp_in3), .dp_in4(h4_dp_in4),
    .dp_out1(h4_dp_out), .rsp_valid(h4_rsp_valid), .rsp_ready(1'b1),
    .rsp_data(h4_rsp_data), .rsp_id(h4_rsp_id)
`ifdef OP_SCHEDULER_PERF_EN
    , .perf_ops_a(h4_perf_a), .perf_ops_b(h4_perf_b), .perf_stall(h4_perf_s)
`endif
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          xcyc;
  } exp_t;

  exp_t sb[$];
  logic id_log[$];
  int   last_xfer   = -1;
  int   last_done   = -1;
  logic ptr_last    = 1'b1;
  int   model_ops_a = 0;
  int   model_ops_b = 0;
  int   model_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // issue side: predict ready from round-robin rules and push expected results
  always @(negedge clk) begin : issue_chk
    logic       idle;
    logic [1:0] exp_rdy;
    exp_t       e;
    if (!rst) begin
      idle    = (last_xfer < 0) || ((last_done > last_xfer) && (last_done < cyc));
      exp_rdy = 2'b00;
      if (idle) exp_rdy = (req_valid == 2'b11) ? (ptr_last ? 2'b01 : 2'b10) : req_valid;
      chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      if ((exp_rdy & req_valid) != 2'b00) begin
        e.id   = exp_rdy[1];
        e.data = stub_force ? stub_val :
                 (e.id ? dp_model(in1_b, in2_b, in3_b, op_b) : dp_model(in1_a, in2_a, in3_a, op_a));
        e.xcyc = cyc;
        sb.push_back(e);
        last_xfer = cyc;
        ptr_last  = e.id;
      end
    end
  end

  // response side: pop and compare whenever a result is due
  always @(negedge clk) begin : rsp_mon
    logic exp_v;
    if (!rst) begin
      exp_v = (sb.size() > 0) && (cyc >= sb[0].xcyc + HOLD_M + 2);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
      if (exp_v && rsp_valid) begin
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, sb[0].id});
      end
      if (exp_v) begin
        if (rsp_ready) begin
          id_log.push_back(rsp_id);
          if (sb[0].id) model_ops_b++;
          else          model_ops_a++;
          void'(sb.pop_front());
          last_done = cyc;
        end else begin
          model_stall++;
        end
      end
    end
  end

  task automatic new_ops(input int r);
    if (r == 0) begin
      in1_a = 16'($urandom); in2_a = 16'($urandom); in3_a = 16'($urandom);
      op_a  = 2'($urandom_range(0, 3));
    end else begin
      in1_b = 16'($urandom); in2_b = 16'($urandom); in3_b = 16'($urandom);
      op_b  = 2'($urandom_range(0, 3));
    end
  endtask

  // mode 0: both requesters always valid, consumer always ready; mode 1: random
  task automatic run_cycles(input int n, input int mode);
    logic [1:0] acc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (acc[r] || !req_valid[r]) begin
          new_ops(r);
          req_valid[r] = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 40);
        end else if ((mode == 1) && ($urandom_range(0, 99) < 5)) begin
          req_valid[r] = 1'b0;
        end
      end
      rsp_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 70);
    end
  endtask

  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin : timeout
    #400000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [15:0] s1, s2, s3;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    stub_force = 1'b0; stub_val = 32'd0;
    new_ops(0); new_ops(1);
    h4_valid = 2'b00; h4_in1 = 16'd0; h4_in2 = 16'd0; h4_in3 = 16'd0; h4_op = 2'b00;
    h4_dp_out = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_dp_in1", {16'd0, dp_in1}, 32'd0);
    chk("rst_dp_in2", {16'd0, dp_in2}, 32'd0);
    chk("rst_dp_in3", {16'd0, dp_in3}, 32'd0);
    chk("rst_dp_in4", {30'd0, dp_in4}, 32'd0);
`ifdef OP_SCHEDULER_PERF_EN
    chk("rst_perf_stall", {16'd0, perf_stall}, 32'd0);
`endif
    #1 rst = 1'b0;

    // simultaneous requests from reset: A, B, A
    run_cycles(14, 0);
    drain();
    chk("tie_count", {31'd0, id_log.size() >= 3}, 32'd1);
    if (id_log.size() >= 3) begin
      chk("tie_id0", {31'd0, id_log[0]}, 32'd0);
      chk("tie_id1", {31'd0, id_log[1]}, 32'd1);
      chk("tie_id2", {31'd0, id_log[2]}, 32'd0);
    end

    // A alone with a fixed datapath result
    stub_force = 1'b1; stub_val = 32'h1234_5678;
    in1_a = 16'h00FF; op_a = 2'b10; req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    chk("testA_id", {31'd0, id_log[id_log.size()-1]}, 32'd0);
    stub_force = 1'b0;

    // backpressure: five RESP cycles with rsp_ready low, A waiting meanwhile
    rsp_ready = 1'b0; new_ops(1); req_valid = 2'b10;
    @(posedge clk); #1;
    new_ops(0); req_valid = 2'b01;
    repeat (7) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();
    chk("bp_id", {31'd0, id_log[id_log.size()-1]}, 32'd1);
`ifdef OP_SCHEDULER_PERF_EN
    chk("perf_stall_bp", {16'd0, perf_stall}, 32'd5);
`endif

    // reset during ISSUE discards the operation
    new_ops(0); op_a = 2'b11; req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("pre_rst_dp_in4", {30'd0, dp_in4}, 32'd3);
    #1 rst = 1'b1;
    sb.delete(); last_xfer = -1; ptr_last = 1'b1;
    model_ops_a = 0; model_ops_b = 0; model_stall = 0;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_dp_in4", {30'd0, dp_in4}, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_cycles(400, 1);
    drain();

    // HOLD=4 instance: operands stable through ISSUE, only the CAPTURE value kept
    s1 = 16'($urandom); s2 = 16'($urandom); s3 = 16'($urandom);
    h4_in1 = s1; h4_in2 = s2; h4_in3 = s3; h4_op = 2'b01; h4_valid = 2'b01;
    h4_dp_out = $urandom;
    @(negedge clk);
    chk("h4_ready", {30'd0, h4_ready}, 32'd1);
    @(posedge clk); #1;
    h4_valid = 2'b00; h4_in1 = ~s1; h4_in2 = ~s2; h4_in3 = ~s3; h4_op = 2'b10;
    h4_dp_out = $urandom;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("h4_dp_in1", {16'd0, h4_dp_in1}, {16'd0, s1});
      chk("h4_dp_in3", {16'd0, h4_dp_in3}, {16'd0, s3});
      chk("h4_dp_in4", {30'd0, h4_dp_in4}, 32'd1);
      chk("h4_no_valid", {31'd0, h4_rsp_valid}, 32'd0);
      @(posedge clk); #1;
      h4_dp_out = (k == 4) ? 32'hCAFE_F00D : $urandom;
    end
    @(negedge clk);
    chk("h4_rsp_valid", {31'd0, h4_rsp_valid}, 32'd1);
    chk("h4_rsp_data", h4_rsp_data, 32'hCAFE_F00D);
    chk("h4_rsp_id", {31'd0, h4_rsp_id}, 32'd0);

`ifdef OP_SCHEDULER_PERF_EN
    chk("perf_ops_a", {16'd0, perf_ops_a}, 32'(model_ops_a));
    chk("perf_ops_b", {16'd0, perf_ops_b}, 32'(model_ops_b));
    chk("perf_stall", {16'd0, perf_stall}, 32'(model_stall));
`endif
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/op_scheduler.md
OP_SCHEDULER -- requirements
Module: op_scheduler

Interface
REQ-001 Parameter DW, default 16, operand width; result width is 2*DW.
REQ-002 Parameter HOLD, default 1, datapath settle cycles between issue and capture (1..4).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  per-requester request valid (bit0 = requester A, bit1 = B).
REQ-006 req_ready  output  2  per-requester accept; a request transfers when valid and ready are both 1.
REQ-007 req_in1_a, req_in2_a, req_in3_a / req_in1_b, req_in2_b, req_in3_b  input  DW each  operands per requester.
REQ-008 req_op_a, req_op_b  input  2  mode select per requester.
REQ-009 dp_in1, dp_in2, dp_in3  output  DW  operands driven to the shared datapath.
REQ-010 dp_in4  output  2  mode select to the shared datapath.
REQ-011 dp_out1  input  2*DW  combinational datapath result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_data  output  2*DW  captured result.
REQ-015 rsp_id  output  1  requester that owns rsp_data (0 = A, 1 = B).

Function
REQ-016 FSM states are IDLE, ISSUE, CAPTURE and RESP, and the FSM SHALL be one-hot or binary at implementer choice.
REQ-017 In IDLE, req_ready is asserted for the arbiter winner only; if no req_valid bit is set, both bits are 0.
REQ-018 Round-robin arbitration: on a tie, grant goes to the requester not granted last; the last-grant pointer resets to B, so A wins the first tie.
REQ-019 On a transfer, the scheduler registers operands, op and id, then moves IDLE->ISSUE.
REQ-020 dp_in1..dp_in4 are driven from registers only and hold stable from ISSUE through CAPTURE; in IDLE and RESP they hold their last value.
REQ-021 ISSUE lasts HOLD cycles, counted by a down-counter, then moves to CAPTURE.
REQ-022 CAPTURE samples dp_out1 into rsp_data in one cycle, then moves to RESP.
REQ-023 RESP asserts rsp_valid; rsp_data and rsp_id are stable until rsp_ready; on handshake the FSM moves to IDLE.
REQ-024 Request-to-rsp_valid latency is HOLD+2 cycles after the transfer edge.
REQ-025 req_ready is 0 outside IDLE; only one operation is in flight at a time.
REQ-026 A requester dropping valid without ready loses no state, and the pointer does not advance.
REQ-027 A rsp_ready pulse while rsp_valid is 0 is ignored.

Reset
REQ-028 Asserting rst at any time, including mid-operation, forces IDLE immediately; the in-flight operation is discarded.
REQ-029 Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, dp_in1..3=0, dp_in4=2'b00, HOLD counter=0, pointer=B.
REQ-030 The first transfer is possible on the first clock edge after rst deasserts.

Configuration
REQ-031 Macro OP_SCHEDULER_PERF_EN is optional.
REQ-032 When OP_SCHEDULER_PERF_EN is defined, the block adds outputs perf_ops_a and perf_ops_b (16-bit, saturating counts of completed RESP handshakes per requester) and perf_stall (16-bit, saturating count of RESP cycles with rsp_ready=0), all cleared by rst.
REQ-033 When OP_SCHEDULER_PERF_EN is undefined, these ports and counters are absent and the rest of the behaviour is identical.

Structure
REQ-034 Package op_sched_pkg holds the FSM state enum, the 2-bit op encoding constants (OP_0..OP_3) and the requester-id constants.
REQ-035 Sub-module rr_arb2 (2-way round-robin: req[1:0], advance, grant[1:0]) is instantiated once.
REQ-036 The shared datapath is external and is not instantiated inside op_scheduler.

Verification
REQ-037 Test A only: A issues in1=16'h00FF, op=2'b10, stub dp_out1=32'h1234_5678, rsp_ready=1 -> rsp_valid at transfer+3 (HOLD=1), rsp_data=32'h1234_5678, rsp_id=0.
REQ-038 Test simultaneous requests: A and B both valid from reset -> A is served first, B next, then A; rsp_id sequence is 0,1,0.
REQ-039 Test backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_data is stable, req_ready stays 2'b00, and with PERF_EN perf_stall=5.
REQ-040 Test reset mid-operation: assert rst during ISSUE -> next cycle rsp_valid=0, dp_in4=0, and the next request completes normally.
REQ-041 Test HOLD=4: dp_in* is stable for 4 ISSUE cycles; dp_out1 changes during ISSUE are ignored, and only the CAPTURE-cycle value appears in rsp_data.
REQ-042 Test saturation, with PERF_EN: 65,540 A operations -> perf_ops_a=16'hFFFF.
